// File: rtl/multi_alarm_reg.sv
// multi_alarm_reg: NUM_ALARMS independent BCD hh:mm alarm slots with enables, minute-tick matching and pending flags.
// Define SNOOZE_EN to add per-slot snooze that re-fires a slot SNOOZE_MIN minutes after a snooze request.
module multi_alarm_reg #(
    parameter int NUM_ALARMS = 4,
    parameter int IDX_W      = 2,
    parameter int SNOOZE_MIN = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_new_alarm,
    input  logic [IDX_W-1:0]      alarm_idx,
    input  logic [3:0]            new_alarm_ms_hr,
    input  logic [3:0]            new_alarm_ls_hr,
    input  logic [3:0]            new_alarm_ms_min,
    input  logic [3:0]            new_alarm_ls_min,
    input  logic                  alarm_en_wr,
    input  logic [NUM_ALARMS-1:0] alarm_en_data,
    input  logic [3:0]            current_time_ms_hr,
    input  logic [3:0]            current_time_ls_hr,
    input  logic [3:0]            current_time_ms_min,
    input  logic [3:0]            current_time_ls_min,
    input  logic                  minute_tick,
    input  logic                  stop_alarm,
    input  logic                  snooze,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [3:0]            alarm_time_ms_hr,
    output logic [3:0]            alarm_time_ls_hr,
    output logic [3:0]            alarm_time_ms_min,
    output logic [3:0]            alarm_time_ls_min,
    output logic [NUM_ALARMS-1:0] alarm_pending,
    output logic                  alarm,
    output logic                  load_err,
    output logic [NUM_ALARMS-1:0] snooze_active
);

    // Each slot is packed as {ms_hr, ls_hr, ms_min, ls_min} so a match is one 16-bit compare.
    logic [15:0]           r_slot [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] r_enable;
    logic [NUM_ALARMS-1:0] r_pending;
    logic                  r_alarm;
    logic                  r_loadErr;

    logic [15:0]           w_newTime;
    logic [15:0]           w_curTime;
    logic [15:0]           w_rdTime;
    logic                  w_idxOk;
    logic                  w_digitsOk;
    logic                  w_loadOk;
    logic [NUM_ALARMS-1:0] w_hit;
    logic [NUM_ALARMS-1:0] w_pendNext;

    assign w_newTime = {new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min};
    assign w_curTime = {current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min};

    assign w_idxOk    = int'(alarm_idx) < NUM_ALARMS;
    assign w_digitsOk = (new_alarm_ms_hr <= 4'd2) && (new_alarm_ls_hr <= 4'd9)
                     && !((new_alarm_ms_hr == 4'd2) && (new_alarm_ls_hr > 4'd3))
                     && (new_alarm_ms_min <= 4'd5) && (new_alarm_ls_min <= 4'd9);
    assign w_loadOk   = w_idxOk && w_digitsOk;

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            w_hit[i] = minute_tick && r_enable[i] && (r_slot[i] == w_curTime);
        end
    end

`ifdef SNOOZE_EN
    logic [15:0]           r_snzTime [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] r_snzActive;
    logic [NUM_ALARMS-1:0] w_snzHit;
    logic [NUM_ALARMS-1:0] w_snzNext;
    logic                  w_snoozeReq;
    logic [4:0]            w_lsMinSum;
    logic [3:0]            w_msMinSum;
    logic                  w_minCarry;
    logic                  w_hrCarry;
    logic [3:0]            w_snzLsMin;
    logic [3:0]            w_snzMsMin;
    logic [3:0]            w_snzLsHr;
    logic [3:0]            w_snzMsHr;
    logic [15:0]           w_snzTarget;

    assign w_snoozeReq = snooze && r_alarm;

    // Digit-wise BCD add of SNOOZE_MIN minutes, carrying into the hour and wrapping 23:5x to 00:0y.
    always_comb begin
        w_lsMinSum = {1'b0, current_time_ls_min} + 5'(SNOOZE_MIN);
        w_minCarry = w_lsMinSum > 5'd9;
        w_snzLsMin = w_minCarry ? 4'(w_lsMinSum - 5'd10) : w_lsMinSum[3:0];
        w_msMinSum = current_time_ms_min + {3'b000, w_minCarry};
        w_hrCarry  = w_msMinSum > 4'd5;
        w_snzMsMin = w_hrCarry ? 4'd0 : w_msMinSum;
        w_snzMsHr  = current_time_ms_hr;
        w_snzLsHr  = current_time_ls_hr;
        if (w_hrCarry) begin
            if ((current_time_ms_hr == 4'd2) && (current_time_ls_hr == 4'd3)) begin
                w_snzMsHr = 4'd0;
                w_snzLsHr = 4'd0;
            end else if (current_time_ls_hr == 4'd9) begin
                w_snzMsHr = current_time_ms_hr + 4'd1;
                w_snzLsHr = 4'd0;
            end else begin
                w_snzLsHr = current_time_ls_hr + 4'd1;
            end
        end
        w_snzTarget = {w_snzMsHr, w_snzLsHr, w_snzMsMin, w_snzLsMin};
    end

    always_comb begin
        w_snzHit = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            w_snzHit[i] = minute_tick && r_snzActive[i] && (r_snzTime[i] == w_curTime);
        end
        w_snzNext = r_snzActive & ~w_snzHit;
        if (w_snoozeReq) w_snzNext = w_snzNext | r_pending;
        if (stop_alarm) w_snzNext = '0;
        if (alarm_en_wr) w_snzNext = w_snzNext & alarm_en_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_snzActive <= '0;
            for (int i = 0; i < NUM_ALARMS; i++) r_snzTime[i] <= '0;
        end else begin
            r_snzActive <= w_snzNext;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (alarm_en_wr && !alarm_en_data[i]) r_snzTime[i] <= '0;
                else if (w_snoozeReq && r_pending[i]) r_snzTime[i] <= w_snzTarget;
            end
        end
    end

    assign snooze_active = r_snzActive;
`else
    logic [1:0] w_unusedSnooze;
    assign w_unusedSnooze = {snooze, SNOOZE_MIN > 0};
    assign snooze_active  = '0;
`endif

    // A fresh hit outranks stop/snooze in the same cycle; disabling a slot outranks everything.
    always_comb begin
        w_pendNext = r_pending;
        if (stop_alarm) w_pendNext = '0;
`ifdef SNOOZE_EN
        if (w_snoozeReq) w_pendNext = '0;
        w_pendNext = w_pendNext | w_hit | w_snzHit;
`else
        w_pendNext = w_pendNext | w_hit;
`endif
        if (alarm_en_wr) w_pendNext = w_pendNext & alarm_en_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ALARMS; i++) r_slot[i] <= '0;
            r_enable  <= '0;
            r_pending <= '0;
            r_alarm   <= 1'b0;
            r_loadErr <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (load_new_alarm && w_loadOk && (int'(alarm_idx) == i)) r_slot[i] <= w_newTime;
            end
            if (alarm_en_wr) r_enable <= alarm_en_data;
            r_pending <= w_pendNext;
            r_alarm   <= |r_pending;
            r_loadErr <= load_new_alarm && !w_loadOk;
        end
    end

    always_comb begin
        w_rdTime = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (int'(rd_idx) == i) w_rdTime = r_slot[i];
        end
    end

    assign alarm_time_ms_hr  = w_rdTime[15:12];
    assign alarm_time_ls_hr  = w_rdTime[11:8];
    assign alarm_time_ms_min = w_rdTime[7:4];
    assign alarm_time_ls_min = w_rdTime[3:0];
    assign alarm_pending     = r_pending;
    assign alarm             = r_alarm;
    assign load_err          = r_loadErr;

endmodule

// File: tb/tb_multi_alarm_reg.sv
// Scoreboard bench for multi_alarm_reg: a 4-slot instance plus a 3-slot instance sharing the same stimulus.
// Snooze expectations switch on SNOOZE_EN so the same bench covers both builds.
module tb_multi_alarm_reg;

    localparam int K_PEND  = 0;
    localparam int K_ALARM = 1;
    localparam int K_ERR   = 2;
    localparam int K_RD    = 3;
    localparam int K_SNZ   = 4;
    localparam int K_ERR3  = 5;
    localparam int K_RD3   = 6;

    logic       clock = 1'b0;
    logic       reset;
    logic       load_new_alarm;
    logic [1:0] alarm_idx;
    logic [3:0] new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min;
    logic       alarm_en_wr;
    logic [3:0] alarm_en_data;
    logic [3:0] current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min;
    logic       minute_tick;
    logic       stop_alarm;
    logic       snooze;
    logic [1:0] rd_idx;

    logic [3:0] alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min;
    logic [3:0] alarm_pending;
    logic       alarm;
    logic       load_err;
    logic [3:0] snooze_active;

    logic [3:0] rd3MsHr, rd3LsHr, rd3MsMin, rd3LsMin;
    logic [2:0] pending3;
    logic       alarm3;
    logic       loadErr3;
    logic [2:0] snzActive3;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] exp;
    } expT;

    expT         sbQ[$];
    logic [15:0] model[4];
    int          compared   = 0;
    int          mismatched = 0;

    always #5 clock = ~clock;

    multi_alarm_reg dut (
        .clock(clock), .reset(reset),
        .load_new_alarm(load_new_alarm), .alarm_idx(alarm_idx),
        .new_alarm_ms_hr(new_alarm_ms_hr), .new_alarm_ls_hr(new_alarm_ls_hr),
        .new_alarm_ms_min(new_alarm_ms_min), .new_alarm_ls_min(new_alarm_ls_min),
        .alarm_en_wr(alarm_en_wr), .alarm_en_data(alarm_en_data),
        .current_time_ms_hr(current_time_ms_hr), .current_time_ls_hr(current_time_ls_hr),
        .current_time_ms_min(current_time_ms_min), .current_time_ls_min(current_time_ls_min),
        .minute_tick(minute_tick), .stop_alarm(stop_alarm), .snooze(snooze), .rd_idx(rd_idx),
        .alarm_time_ms_hr(alarm_time_ms_hr), .alarm_time_ls_hr(alarm_time_ls_hr),
        .alarm_time_ms_min(alarm_time_ms_min), .alarm_time_ls_min(alarm_time_ls_min),
        .alarm_pending(alarm_pending), .alarm(alarm), .load_err(load_err),
        .snooze_active(snooze_active)
    );

    multi_alarm_reg #(.NUM_ALARMS(3), .IDX_W(2)) dut3 (
        .clock(clock), .reset(reset),
        .load_new_alarm(load_new_alarm), .alarm_idx(alarm_idx),
        .new_alarm_ms_hr(new_alarm_ms_hr), .new_alarm_ls_hr(new_alarm_ls_hr),
        .new_alarm_ms_min(new_alarm_ms_min), .new_alarm_ls_min(new_alarm_ls_min),
        .alarm_en_wr(alarm_en_wr), .alarm_en_data(alarm_en_data[2:0]),
        .current_time_ms_hr(current_time_ms_hr), .current_time_ls_hr(current_time_ls_hr),
        .current_time_ms_min(current_time_ms_min), .current_time_ls_min(current_time_ls_min),
        .minute_tick(minute_tick), .stop_alarm(stop_alarm), .snooze(snooze), .rd_idx(rd_idx),
        .alarm_time_ms_hr(rd3MsHr), .alarm_time_ls_hr(rd3LsHr),
        .alarm_time_ms_min(rd3MsMin), .alarm_time_ls_min(rd3LsMin),
        .alarm_pending(pending3), .alarm(alarm3), .load_err(loadErr3),
        .snooze_active(snzActive3)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_PEND:  observe = {28'd0, alarm_pending};
            K_ALARM: observe = {31'd0, alarm};
            K_ERR:   observe = {31'd0, load_err};
            K_RD:    observe = {16'd0, alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min};
            K_SNZ:   observe = {28'd0, snooze_active};
            K_ERR3:  observe = {31'd0, loadErr3};
            K_RD3:   observe = {16'd0, rd3MsHr, rd3LsHr, rd3MsMin, rd3LsMin};
            default: observe = 'x;
        endcase
    endfunction

    task automatic expectVal(input string tag, input int kind, input logic [31:0] exp);
        expT e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = exp;
        sbQ.push_back(e);
    endtask

    task automatic drainScoreboard();
        while (sbQ.size() > 0) begin
            expT e;
            e = sbQ.pop_front();
            checkOutput(e.tag, observe(e.kind), e.exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkAllSlots();
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i);
            #1;
            expectVal($sformatf("readback_slot%0d", i), K_RD, {16'd0, model[i]});
            drainScoreboard();
        end
    endtask

    // Load one slot, checking the error pulse on both instances and the full readback afterwards.
    task automatic applyStimulus(input int idx, input logic [3:0] h1, input logic [3:0] h0,
                                 input logic [3:0] m1, input logic [3:0] m0);
        logic digitsOk;
        digitsOk = (h1 <= 4'd2) && (h0 <= 4'd9) && !((h1 == 4'd2) && (h0 > 4'd3))
                && (m1 <= 4'd5) && (m0 <= 4'd9);
        load_new_alarm   = 1'b1;
        alarm_idx        = 2'(idx);
        new_alarm_ms_hr  = h1;
        new_alarm_ls_hr  = h0;
        new_alarm_ms_min = m1;
        new_alarm_ls_min = m0;
        expectVal("load_err", K_ERR, {31'd0, !digitsOk});
        expectVal("load_err3", K_ERR3, {31'd0, !(digitsOk && (idx < 3))});
        if (digitsOk) model[idx] = {h1, h0, m1, m0};
        step();
        load_new_alarm = 1'b0;
        drainScoreboard();
        step();
        expectVal("load_err_clear", K_ERR, 32'd0);
        drainScoreboard();
        checkAllSlots();
    endtask

    task automatic writeMask(input logic [3:0] mask, input logic [3:0] expPend);
        alarm_en_wr   = 1'b1;
        alarm_en_data = mask;
        expectVal("pending_after_mask", K_PEND, {28'd0, expPend});
        step();
        alarm_en_wr = 1'b0;
        drainScoreboard();
    endtask

    task automatic minuteTick(input logic [3:0] h1, input logic [3:0] h0, input logic [3:0] m1,
                              input logic [3:0] m0, input logic stop, input logic [3:0] expPend);
        current_time_ms_hr  = h1;
        current_time_ls_hr  = h0;
        current_time_ms_min = m1;
        current_time_ls_min = m0;
        minute_tick = 1'b1;
        stop_alarm  = stop;
        expectVal("pending_after_tick", K_PEND, {28'd0, expPend});
        step();
        minute_tick = 1'b0;
        stop_alarm  = 1'b0;
        drainScoreboard();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0;
        load_new_alarm = 1'b0; alarm_idx = '0;
        new_alarm_ms_hr = '0; new_alarm_ls_hr = '0; new_alarm_ms_min = '0; new_alarm_ls_min = '0;
        alarm_en_wr = 1'b0; alarm_en_data = '0;
        current_time_ms_hr = '0; current_time_ls_hr = '0; current_time_ms_min = '0; current_time_ls_min = '0;
        minute_tick = 1'b0; stop_alarm = 1'b0; snooze = 1'b0; rd_idx = '0;
        for (int i = 0; i < 4; i++) model[i] = '0;

        repeat (2) @(posedge clock);
        #1;
        expectVal("reset_pending", K_PEND, 32'd0);
        expectVal("reset_alarm", K_ALARM, 32'd0);
        expectVal("reset_load_err", K_ERR, 32'd0);
        expectVal("reset_readback", K_RD, 32'd0);
        expectVal("reset_snooze_active", K_SNZ, 32'd0);
        drainScoreboard();
        reset = 1'b1;
        step();

        applyStimulus(2, 4'd0, 4'd7, 4'd3, 4'd0);
        applyStimulus(1, 4'd2, 4'd4, 4'd0, 4'd0);
        applyStimulus(1, 4'd1, 4'd2, 4'd6, 4'd0);
        applyStimulus(3, 4'd2, 4'd3, 4'd5, 4'd9);
        rd_idx = 2'd3;
        #1;
        expectVal("readback3_out_of_range", K_RD3, 32'd0);
        drainScoreboard();

        applyStimulus(0, 4'd0, 4'd6, 4'd1, 4'd5);
        writeMask(4'b0001, 4'b0000);
        minuteTick(4'd0, 4'd6, 4'd1, 4'd5, 1'b0, 4'b0001);
        expectVal("alarm_lags_pending", K_ALARM, 32'd0);
        drainScoreboard();
        step();
        expectVal("alarm_raised", K_ALARM, 32'd1);
        drainScoreboard();
        stop_alarm = 1'b1;
        expectVal("pending_after_stop", K_PEND, 32'd0);
        step();
        stop_alarm = 1'b0;
        drainScoreboard();
        step();
        expectVal("alarm_after_stop", K_ALARM, 32'd0);
        drainScoreboard();

        writeMask(4'b0000, 4'b0000);
        minuteTick(4'd0, 4'd6, 4'd1, 4'd5, 1'b0, 4'b0000);
        step();
        expectVal("alarm_disabled_slot", K_ALARM, 32'd0);
        drainScoreboard();

        applyStimulus(3, 4'd1, 4'd2, 4'd0, 4'd0);
        writeMask(4'b1000, 4'b0000);
        minuteTick(4'd1, 4'd2, 4'd0, 4'd0, 1'b1, 4'b1000);
        step();
        expectVal("alarm_match_beats_stop", K_ALARM, 32'd1);
        drainScoreboard();

        reset = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = '0;
        #1;
        expectVal("midreset_pending", K_PEND, 32'd0);
        expectVal("midreset_alarm", K_ALARM, 32'd0);
        expectVal("midreset_load_err", K_ERR, 32'd0);
        expectVal("midreset_readback", K_RD, 32'd0);
        drainScoreboard();
        reset = 1'b1;
        step();

        applyStimulus(3, 4'd1, 4'd2, 4'd0, 4'd0);
        writeMask(4'b1000, 4'b0000);
        minuteTick(4'd1, 4'd2, 4'd0, 4'd1, 1'b0, 4'b0000);
        minuteTick(4'd1, 4'd2, 4'd0, 4'd0, 1'b0, 4'b1000);
        writeMask(4'b0000, 4'b0000);
        step();
        step();
        expectVal("alarm_after_disable", K_ALARM, 32'd0);
        drainScoreboard();

        applyStimulus(0, 4'd2, 4'd3, 4'd5, 4'd7);
        writeMask(4'b0001, 4'b0000);
        minuteTick(4'd2, 4'd3, 4'd5, 4'd7, 1'b0, 4'b0001);
        step();
        expectVal("alarm_before_snooze", K_ALARM, 32'd1);
        drainScoreboard();
        snooze = 1'b1;
`ifdef SNOOZE_EN
        expectVal("pending_after_snooze", K_PEND, 32'd0);
        expectVal("snooze_armed", K_SNZ, 32'd1);
`else
        expectVal("pending_snooze_ignored", K_PEND, 32'd1);
        expectVal("snooze_active_tied", K_SNZ, 32'd0);
`endif
        step();
        snooze = 1'b0;
        drainScoreboard();
        step();
        minuteTick(4'd0, 4'd0, 4'd0, 4'd2, 1'b0, 4'b0001);
        expectVal("snooze_active_after_refire", K_SNZ, 32'd0);
        drainScoreboard();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
